// File: rtl/oc8051_ifetch.sv
// oc8051_ifetch: fetch stage that owns the PC, addresses the program ROM and presents the
// opcode plus two operand bytes to the decoder. OC8051_XROM_EN builds the external ROM path.
module oc8051_ifetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        ea_pin,
    output logic [15:0] rom_addr,
    input  logic        rom_ea_int,
    input  logic [7:0]  rom_data1,
    input  logic [7:0]  rom_data2,
    input  logic [7:0]  rom_data3,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [7:0]  op3,
    output logic [15:0] op_pc,
    output logic        op_valid,
    input  logic        dec_take,
    input  logic [1:0]  dec_len,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic [15:0] ext_addr,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [7:0]  ext_data
);

    typedef enum logic [2:0] {
        RST  = 3'd0,
        INT  = 3'd1,
        EXT0 = 3'd2,
        EXT1 = 3'd3,
        EXT2 = 3'd4,
        EXTV = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] nfa;

    // The ROM is addressed with the next-fetch address so its one-cycle latency is hidden.
    always_comb begin
        op_valid = (state_q == INT) || (state_q == EXTV);
        if (op_valid && jmp) begin
            nfa = jmp_addr;
        end else if (op_valid && dec_take) begin
            nfa = pc_q + {14'd0, dec_len};
        end else begin
            nfa = pc_q;
        end
        pc_d = (op_valid || (state_q == RST)) ? nfa : pc_q;
    end

    assign rom_addr = nfa;
    assign op_pc    = pc_q;

`ifdef OC8051_XROM_EN
    logic       int_ok;
    logic       consume;
    logic [7:0] buf0_q, buf1_q, buf2_q;
    logic [7:0] buf0_d, buf1_d, buf2_d;

    // Decided on the address of op1 only; a triple straddling the boundary stays internal.
    assign int_ok  = ea_pin & rom_ea_int;
    assign consume = op_valid & (dec_take | jmp);

    always_comb begin
        state_d  = state_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        buf2_d   = buf2_q;
        ext_req  = 1'b0;
        ext_addr = '0;
        case (state_q)
            RST, INT: begin
                state_d = int_ok ? INT : EXT0;
            end
            EXT0: begin
                ext_req  = 1'b1;
                ext_addr = pc_q;
                if (ext_ack) begin
                    buf0_d  = ext_data;
                    state_d = EXT1;
                end
            end
            EXT1: begin
                ext_req  = 1'b1;
                ext_addr = pc_q + 16'd1;
                if (ext_ack) begin
                    buf1_d  = ext_data;
                    state_d = EXT2;
                end
            end
            EXT2: begin
                ext_req  = 1'b1;
                ext_addr = pc_q + 16'd2;
                if (ext_ack) begin
                    buf2_d  = ext_data;
                    state_d = EXTV;
                end
            end
            EXTV: begin
                if (consume) begin
                    state_d = int_ok ? INT : EXT0;
                end
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    always_comb begin
        case (state_q)
            INT:     {op1, op2, op3} = {rom_data1, rom_data2, rom_data3};
            EXTV:    {op1, op2, op3} = {buf0_q, buf1_q, buf2_q};
            default: {op1, op2, op3} = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf0_q <= '0;
            buf1_q <= '0;
            buf2_q <= '0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            buf2_q <= buf2_d;
        end
    end
`else
    logic unused_xrom;

    assign unused_xrom = ^{ea_pin, rom_ea_int, ext_ack, ext_data};
    assign ext_req     = 1'b0;
    assign ext_addr    = '0;

    always_comb begin
        state_d = INT;
        {op1, op2, op3} = (state_q == INT) ? {rom_data1, rom_data2, rom_data3} : 24'h0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule
